// File: rtl/siso_pkg.sv
// Shared SISO decoder definitions: metric-buffer sequencer states and the
// default word width / block depth used by the alpha, beta and LIFO units.
package siso_pkg;

  localparam int SISO_DWIDTH = 16;
  localparam int SISO_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } lifo_state_e;

endpackage

// File: rtl/custom_ram.sv
// Simple dual-port RAM: one synchronous write port, one read port with a
// registered (1-cycle) output. Contents are never reset.
module custom_ram #(
  parameter  int DWIDTH = 16,
  parameter  int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/alpha_lifo_ctrl.sv
// Metric-buffer sequencer: stores one block of forward metrics in arrival order
// and replays it newest-first for the backward recursion.
//
// state | meaning
// IDLE  | waiting for start; length checked here
// FILL  | accepting s_* beats, writing address wcnt
// DRAIN | reading L-1 down to 0 onto m_*
module alpha_lifo_ctrl
  import siso_pkg::*;
#(
  parameter  int DWIDTH = SISO_DWIDTH,
  parameter  int DEPTH  = SISO_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [AW:0]       blk_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  lifo_state_e state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] wcnt_q, wcnt_d;
  logic [AW:0] rd_addr_q, rd_addr_d;
  logic        m_valid_q, m_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [AW:0] len_m1;
  logic        len_ok;
  logic        wr_beat;

  assign len_m1  = len_q - ONE_W;
  assign len_ok  = (blk_len != '0) && (blk_len <= DEPTH_W);
  assign s_ready = (state_q == FILL);
  assign wr_beat = s_valid & s_ready;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign m_valid = m_valid_q;
  // rd_addr_q names the word currently on m_data; it reaches address 0 last.
  assign m_last  = m_valid_q & (rd_addr_q == '0);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    rd_addr_d = rd_addr_q;
    m_valid_d = m_valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = blk_len;
            wcnt_d  = '0;
            state_d = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (wr_beat) begin
          wcnt_d = wcnt_q + ONE_W;
          if (wcnt_q == len_m1) begin
            wcnt_d    = '0;
            rd_addr_d = len_m1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
        end else if (m_ready) begin
          if (rd_addr_q == '0) begin
            m_valid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            rd_addr_d = rd_addr_q - ONE_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      rd_addr_q <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      rd_addr_q <= rd_addr_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Reading the next-address value keeps m_data stable on a stall and
  // bubble-free when m_ready stays high.
  custom_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_beat),
    .wr_addr (wcnt_q[AW-1:0]),
    .wr_data (s_data),
    .rd_addr (rd_addr_d[AW-1:0]),
    .rd_data (m_data)
  );

endmodule

// File: tb/tb_alpha_lifo_ctrl.sv
// Directed bench for alpha_lifo_ctrl: input beats push expected words onto a
// LIFO scoreboard, output beats pop and compare them.
module tb_alpha_lifo_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [AW:0]   blk_len;
  logic          busy, done, err;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 aclk = ~aclk;

  alpha_lifo_ctrl #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .start   (start),
    .blk_len (blk_len),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [DW-1:0] gen(input int mode, input int i, input int seed);
    case (mode)
      0:       return DW'((i + 1) * 17);
      1:       return DW'(i);
      default: return DW'(seed * 4099 + i * 613 + 23100);
    endcase
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_done"},    done,    0);
    chk({tag, "_err"},     err,     0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"},  m_last,  0);
  endtask

  // gap_mode 1: s_valid every other cycle. rdy_mode 1: m_ready 1,0,0 repeating.
  task automatic run_block(input int len, input int gap_mode, input int rdy_mode,
                           input int data_mode, input bit pre_started, input bit poke_start,
                           input int abort_at, input int next_len);
    int   cyc, wr_n, pops, first_v, last_wr, last_pop, rc;
    bit   prev_stall, fin, aborted;
    logic [DW-1:0] prev_data;
    exp_t e;
    if (!pre_started) begin
      @(negedge aclk);
      start   = 1'b1;
      blk_len = (AW+1)'(len);
    end
    @(negedge aclk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wr_n = 0; pops = 0; first_v = -1; last_wr = -1; last_pop = 0; rc = 0;
    prev_stall = 0; fin = 0; aborted = 0; prev_data = '0;
    for (cyc = 0; cyc < len * 4 + 40 && !fin; cyc++) begin
      if (pops == len) begin
        chk("done_pulse", done, 1);
        chk("m_valid_after_last", m_valid, 0);
        chk("busy_after_done", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
        s_valid = 1'b0;
        m_ready = 1'b0;
        if (next_len > 0) begin
          start   = 1'b1;
          blk_len = (AW+1)'(next_len);
        end
        fin = 1;
      end else if (abort_at >= 0 && pops == abort_at && m_valid) begin
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1 areset = 1'b1;
        #1 chk_idle_outputs("reset_mid_drain");
        #1 areset = 1'b0;
        exp_q.delete();
        aborted = 1;
        fin = 1;
      end else begin
        if (done) chk("spurious_done", done, 0);
        start   = (poke_start && cyc == 1);
        blk_len = (poke_start && cyc == 1) ? (AW+1)'(5) : blk_len;
        s_valid = 1'b0;
        if (wr_n < len) begin
          chk("s_ready_fill", s_ready, 1);
          if (gap_mode == 0 || cyc % 2 == 0) begin
            s_valid = 1'b1;
            s_data  = gen(data_mode, wr_n, len);
            if (s_ready) begin
              e.data = s_data;
              e.last = (wr_n == 0);
              exp_q.push_front(e);
              wr_n++;
              last_wr = cyc;
            end
          end
        end else if (cyc == last_wr + 1) begin
          chk("s_ready_drop", s_ready, 0);
        end
        m_ready = 1'b0;
        if (m_valid) begin
          if (first_v < 0) begin
            first_v = cyc;
            chk("m_valid_latency", cyc - last_wr, 2);
          end
          if (prev_stall) chk("stall_stable", m_data, prev_data);
          m_ready = (rdy_mode == 0) ? 1'b1 : (rc % 3 == 0);
          rc++;
          if (m_ready) begin
            if (exp_q.size() == 0) begin
              chk("sb_underflow", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              chk("m_data", m_data, e.data);
              chk("m_last", m_last, e.last);
            end
            pops++;
            last_pop   = cyc;
            prev_stall = 0;
          end else begin
            prev_stall = 1;
            prev_data  = m_data;
          end
        end else if (first_v >= 0) begin
          chk("m_valid_dropped", m_valid, 1);
        end
      end
      if (!fin) @(negedge aclk);
    end
    chk("block_finished", fin, 1);
    if (fin && !aborted && rdy_mode == 0) chk("no_bubbles", last_pop - first_v, len - 1);
  endtask

  task automatic bad_len(input int len);
    @(negedge aclk);
    start   = 1'b1;
    blk_len = (AW+1)'(len);
    @(negedge aclk);
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_s_ready", s_ready, 0);
    @(negedge aclk);
    chk("err_one_cycle", err, 0);
    chk("err_still_idle", busy, 0);
  endtask

  initial begin
    areset  = 1'b1;
    start   = 1'b0;
    blk_len = '0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge aclk);
    chk_idle_outputs("reset");
    areset = 1'b0;

    run_block(4,   0, 0, 0, 0, 0, -1, 0);
    run_block(8,   0, 1, 2, 0, 0, -1, 0);
    run_block(1,   0, 0, 2, 0, 0, -1, 0);
    run_block(256, 0, 0, 1, 0, 0, -1, 0);
    bad_len(0);
    bad_len(257);
    run_block(6,   0, 0, 2, 0, 1, -1, 0);
    run_block(16,  1, 0, 2, 0, 0, -1, 0);
    run_block(8,   0, 0, 2, 0, 0, 3, 0);
    @(negedge aclk);
    chk_idle_outputs("after_reset");
    run_block(3,   0, 0, 0, 0, 0, -1, 5);
    run_block(5,   0, 1, 2, 1, 0, -1, 0);
    @(negedge aclk);
    chk_idle_outputs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alpha_lifo_ctrl.md
Name: alpha_lifo_ctrl

Overview:
Sequencer for the SISO decoder's metric buffer: accepts one block of forward-recursion metrics in arrival order and replays them in reverse order for the backward recursion.
Instantiates one custom_ram (simple dual-port, 1-cycle registered read) and owns all of its write and read addressing.
Sits between the alpha unit (stream in) and the beta/LLR unit (stream out), with valid/ready handshakes on both sides.

Parameters:
DWIDTH, 16, metric word width (passed to the RAM)
DEPTH, 256, maximum block length in words (passed to the RAM); AW = $clog2(DEPTH)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a block; sampled only in IDLE
blk_len  in  AW+1  block length, legal range 1..DEPTH; latched on accepted start
busy  out  1  high in FILL and DRAIN
done  out  1  one-cycle pulse after the last output beat is accepted
err  out  1  one-cycle pulse when start is sampled in IDLE with an illegal blk_len
s_valid  in  1  input metric valid
s_ready  out  1  input ready
s_data  in  DWIDTH  input metric
m_valid  out  1  output metric valid
m_ready  in  1  output ready
m_data  out  DWIDTH  output metric (driven by RAM data_out)
m_last  out  1  high with the final output beat (RAM address 0)

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, err, s_ready, m_valid and m_last = 0; counters = 0. RAM contents are not cleared.
- IDLE:
  - start=1 with blk_len in 1..DEPTH: latch the length as L and go to FILL.
  - start=1 with blk_len = 0 or > DEPTH: pulse err for one cycle and stay in IDLE.
- start is ignored outside IDLE.
- FILL:
  - s_ready = 1.
  - Each s_valid&s_ready beat writes s_data to address wcnt, then increments wcnt (wcnt starts at 0).
  - On the L-th beat, go to DRAIN. s_ready is 0 from the next cycle.
- DRAIN:
  - Read addresses L-1 down to 0 in order.
  - The first read address is presented in the first DRAIN cycle.
  - m_valid rises in the following cycle, i.e. 2 cycles after the final write handshake edge.
  - The final write is committed before the first read, so there is no same-address hazard.
- Output handshake:
  - A beat transfers when m_valid&m_ready.
  - With m_ready held high, one beat is delivered per cycle with no bubbles.
  - While m_valid&!m_ready: rd_addr is held, so the RAM re-reads the same word and m_data stays stable.
  - m_valid must not drop until the beat is accepted.
- m_last = m_valid while the word from address 0 is presented.
- When the m_last beat is accepted: m_valid = 0 and done = 1 next cycle, state returns to IDLE.
  - A start in that done cycle is accepted (back-to-back blocks).
- The L = 1 boundary case works: one write, then one output beat with m_last = 1.
- The L = DEPTH boundary case works: address wraps are never needed, and the counters are AW+1 wide to hold L.
- Async reset mid-FILL or mid-DRAIN aborts the block; the next start begins a fresh block.
- No write-enable to the RAM outside FILL handshakes.

Decomposition:
- A shared siso package holds:
  - the FSM state enum (IDLE, FILL, DRAIN);
  - the default DWIDTH/DEPTH constants shared with the alpha/beta units.
- Sub-module: custom_ram (existing), instantiated once; no other sub-modules.

Test Plan:
1. L=4, inputs 0x0011,0x0022,0x0033,0x0044, m_ready=1 -> outputs 0x0044,0x0033,0x0022,0x0011 on 4 consecutive cycles; m_last on 0x0011; done pulse one cycle later; first m_valid 2 cycles after the 4th write.
2. L=8, m_ready toggled 1,0,0,1,... -> order preserved, m_data stable during each stall, no beat dropped or duplicated.
3. L=1 and L=DEPTH (256, ramp data 0..255) -> single beat with m_last=1; ramp returned 255..0, m_last on 0.
4. blk_len=0 and blk_len=257 -> err pulses, busy stays 0, no RAM write. start asserted during FILL -> ignored.
5. Gapped input (s_valid 50%) for L=16 -> every word written once; s_ready=0 after the 16th beat.
6. areset asserted mid-DRAIN -> all outputs 0 immediately. New L=3 block completes correctly. Back-to-back start in the done cycle -> accepted.
